// File: rtl/if_id_queue_pkg.sv
// Shared widths and constants for the IF/ID queue: default pc/instruction widths,
// the bubble word, and boolean literals.
package if_id_queue_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;
  localparam logic               True_v   = 1'b1;
  localparam logic               False_v  = 1'b0;
endpackage

// File: rtl/if_id_queue_mem.sv
// DEPTH-entry register array with one write port and one combinational read port.
// Data is deliberately not reset; validity is tracked by the control logic.
module if_id_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode FIFO of {pc, inst} pairs with flush, global ready and bubble-on-empty.
// Optional same-cycle empty bypass when IF_ID_QUEUE_BYPASS_EN is defined.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int      XLEN   = InstAddrBus,
  parameter int      INST_W = InstBus,
  parameter int      DEPTH  = 4,
  localparam int     CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  output logic              id_valid,
  output logic [XLEN-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int W     = XLEN + INST_W;

  // Handshake: a transfer happens on a rising edge where valid && ready && rdy && !flush.
  // if_ready depends only on registered occupancy; id_valid may depend on if_valid
  // only in the bypass build. Valid must be held until the transfer occurs.
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic [W-1:0]     head_data;
  logic             empty, full;
  logic             push, pop, bypass_hit, bypass_consume;
  logic             wr_en, rd_adv;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign if_ready = !full;
  assign count    = count_q;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass_hit = empty & if_valid & rdy & !flush;
`else
  assign bypass_hit = False_v;
`endif

  assign id_valid = !empty | bypass_hit;
  assign push     = rdy & if_valid & if_ready & !flush;
  assign pop      = rdy & id_valid & id_ready & !flush;

  // A bypassed entry consumed the same cycle never touches storage or pointers.
  assign bypass_consume = bypass_hit & id_ready;
  assign wr_en          = push & !bypass_consume;
  assign rd_adv         = pop & !bypass_consume;

  always_comb begin
    id_pc   = '0;
    id_inst = '0;
    if (bypass_hit) begin
      id_pc   = if_pc;
      id_inst = if_inst;
    end else if (!empty) begin
      {id_pc, id_inst} = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (wr_en)  wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_adv) rd_ptr <= rd_ptr + PTR_W'(1);
        if (wr_en && !rd_adv)      count_q <= count_q + CNT_W'(1);
        else if (rd_adv && !wr_en) count_q <= count_q - CNT_W'(1);
      end
    end
  end

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en & !rst),
    .waddr (wr_ptr),
    .wdata ({if_pc, if_inst}),
    .raddr (rd_ptr),
    .rdata (head_data)
  );
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed steps then random traffic, compared each
// cycle against a queue-based reference model (bypass rules follow IF_ID_QUEUE_BYPASS_EN).
module tb_if_id_queue;
  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int W      = XLEN + INST_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              flush;
  logic              if_valid;
  logic [XLEN-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_ready;
  logic [CNT_W-1:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: entries in arrival order, head at index 0.
  logic [W-1:0] exp_q[$];

  if_id_queue #(.XLEN(XLEN), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .flush    (flush),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_ready (id_ready),
    .count    (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_valid = 1'b1;
    if_pc = 32'hdead; if_inst = 32'hbeef; id_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_id_valid", 64'(id_valid), 64'(0));
    chk("rst_id_pc", 64'(id_pc), 64'(0));
    chk("rst_id_inst", 64'(id_inst), 64'(0));
    chk("rst_if_ready", 64'(if_ready), 64'(1));
  endtask

  // One clock of stimulus: drive, check outputs against the model, then advance the model.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [XLEN-1:0] pc, input logic [INST_W-1:0] inst,
                      input logic idr);
    logic [W-1:0] head;
    logic         ev, byp, do_push, do_pop;
    int           sz;
    @(negedge clk);
    rdy = r; flush = f; if_valid = v; if_pc = pc; if_inst = inst; id_ready = idr;
    #1;
    sz  = exp_q.size();
    byp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
    byp = (sz == 0) && r && v && !f;
`endif
    ev   = (sz != 0) || byp;
    head = (sz != 0) ? exp_q[0] : (byp ? {pc, inst} : '0);
    chk("if_ready", 64'(if_ready), 64'(sz < DEPTH));
    chk("id_valid", 64'(id_valid), 64'(ev));
    chk("id_pc", 64'(id_pc), 64'(head[W-1:INST_W]));
    chk("id_inst", 64'(id_inst), 64'(head[INST_W-1:0]));
    chk("count", 64'(count), 64'(sz));
    chk("count_bound", 64'(count <= DEPTH), 64'(1));
    @(posedge clk);
    if (r && f) begin
      exp_q.delete();
    end else if (r) begin
      do_push = v && (sz < DEPTH);
      do_pop  = ev && idr;
      if (!(byp && idr)) begin
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({pc, inst});
      end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; flush = 1'b0; if_valid = 1'b0;
    if_pc = '0; if_inst = '0; id_ready = 1'b0;

    do_reset(2);

    // single push, visible next cycle
    step(1, 0, 1, 32'h1000, 32'h00000013, 0);
    step(1, 0, 0, 32'h0, 32'h0, 0);
    chk("first_push_pc", 64'(id_pc), 64'h1000);
    step(1, 0, 0, 32'h0, 32'h0, 1);

    // fill to full, then a held fifth push, then drain in order
    for (int i = 0; i < 4; i++) step(1, 0, 1, 32'(i * 4), 32'h100 + 32'(i), 0);
    step(1, 0, 1, 32'h10, 32'h104, 0);
    chk("full_count", 64'(count), 64'(DEPTH));
    step(1, 0, 1, 32'h10, 32'h104, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h0, 32'h0, 1);

    // continuous push and pop, pointers wrap
    for (int i = 0; i < 10; i++) step(1, 0, 1, 32'h200 + 32'(i * 4), 32'h300 + 32'(i), 1);
    step(1, 0, 0, 32'h0, 32'h0, 1);

    // flush with wrong-path data present
    for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h20 + 32'(i * 4), 32'h400 + 32'(i), 0);
    step(1, 1, 1, 32'h40, 32'h440, 1);
    step(1, 0, 0, 32'h0, 32'h0, 1);
    chk("flush_count", 64'(count), 64'(0));
    step(1, 0, 0, 32'h0, 32'h0, 1);

    // global stall holds everything
    for (int i = 0; i < 2; i++) step(1, 0, 1, 32'h50 + 32'(i * 4), 32'h500 + 32'(i), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h60, 32'h600, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 32'h0, 1);

    // empty queue, push with decode ready (bypass rules differ per build)
    step(1, 0, 1, 32'h80, 32'h800, 1);
    step(1, 0, 0, 32'h0, 32'h0, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));

    // mid-stream reset drops all entries
    for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h90 + 32'(i * 4), 32'h900 + 32'(i), 0);
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 32'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
